motoro3_ramp_sched: RTL and testbench

//  Command sequencer in front of the 3-phase bridge driver.
//  - Accepts run/stop, direction and target speed-level commands.
//  - Drives the driver's start, forceStop, invRotate, freqINC and freqDEC inputs.
//  - Paces INC/DEC pulses so speed ramps up and down smoothly.
//  - Direction reversal is safe: ramp to zero, coast with bridge off, then restart.
//  - Any fault forces an immediate stop.

---
 rtl/motoro3_sched_pkg.sv | 22 ++
 rtl/motoro3_pace_timer.sv | 37 +++
 rtl/motoro3_ramp_sched.sv | 273 +++++++++++++++++++++++++++
 tb/tb_motoro3_ramp_sched.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motoro3_sched_pkg.sv
// Shared types and defaults for the motoro3 ramp scheduler.
package motoro3_sched_pkg;

    localparam int unsigned LVL_W_DEF   = 4;
    localparam int unsigned MAX_LVL_DEF = 12;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RAMP,
        RUN,
        BRAKE,
        COAST,
        FAULT
    } schedState_t;

    // Requested levels above the legal maximum are pinned to the maximum.
    function automatic int unsigned clampLvl(input int unsigned lvl, input int unsigned maxLvl);
        return (lvl > maxLvl) ? maxLvl : lvl;
    endfunction

endpackage

// File: rtl/motoro3_pace_timer.sv
// Loadable down-counter producing a single-cycle tick when it reaches zero.
// Load with (period - 1) to get a tick exactly 'period' cycles after the load edge.
module motoro3_pace_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clkI,
    input  logic             rstI,
    input  logic             loadI,
    input  logic [CNT_W-1:0] loadValI,
    output logic             tickO
);

    logic [CNT_W-1:0] cnt;
    logic             armed;

    // Count down while armed; a load restarts the period and wins over an expiring tick.
    always_ff @(posedge clkI) begin
        // NOTE: clocked state is updated only with non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rstI) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (loadI) begin
            cnt   <= loadValI;
            armed <= 1'b1;
        end else if (armed) begin
            if (cnt == '0) begin
                armed <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign tickO = armed && (cnt == '0);

endmodule

// File: rtl/motoro3_ramp_sched.sv
// Command sequencer for the 3-phase bridge driver: paces INC/DEC pulses to ramp
// speed, reverses direction via brake/coast/restart, and stops hard on faults.
// Optional command watchdog (and the wdogO port) enabled by defining M3SCHED_WDOG_EN.
module motoro3_ramp_sched
    import motoro3_sched_pkg::*;
#(
    parameter int unsigned LVL_W     = LVL_W_DEF,
    parameter int unsigned MAX_LVL   = MAX_LVL_DEF,
    parameter int unsigned STEP_CYC  = 1000,
    parameter int unsigned COAST_CYC = 5000
`ifdef M3SCHED_WDOG_EN
    ,
    parameter int unsigned WDOG_CYC  = 2**20
`endif
) (
    input  logic             clkI,
    input  logic             rstI,
    input  logic             cmdValidI,
    output logic             cmdReadyO,
    input  logic             cmdRunI,
    input  logic             cmdDirI,
    input  logic [LVL_W-1:0] cmdLvlI,
    input  logic             faultI,
    input  logic             faultClrI,
    output logic             m3startO,
    output logic             m3forceStopO,
    output logic             m3invRotateO,
    output logic             m3freqINCo,
    output logic             m3freqDECo,
    output logic [LVL_W-1:0] curLvlO,
    output logic             busyO
`ifdef M3SCHED_WDOG_EN
    ,
    output logic             wdogO
`endif
);

    localparam int unsigned PACE_MAX = (STEP_CYC > COAST_CYC) ? STEP_CYC : COAST_CYC;
    localparam int unsigned PACE_W   = $clog2(PACE_MAX);
    localparam logic [PACE_W-1:0] STEP_LOAD  = PACE_W'(STEP_CYC - 1);
    localparam logic [PACE_W-1:0] COAST_LOAD = PACE_W'(COAST_CYC - 1);
    localparam logic [LVL_W-1:0]  LVL_MAX    = LVL_W'(MAX_LVL);

    schedState_t state, stateNext;

    logic [LVL_W-1:0]  tgt, tgtNext;
    logic [LVL_W-1:0]  cur, curNext;
    logic [LVL_W-1:0]  pendTgt, pendTgtNext;
    logic              pendValid, pendValidNext;
    logic              pendDir, pendDirNext;
    logic              invQ, invNext;
    logic              incNext, decNext;
    logic              startQ, forceStopQ, incQ, decQ;
    logic              timerLoad;
    logic [PACE_W-1:0] timerVal;
    logic              paceTick;
    logic              accept;
    logic              wdogTrip;
    logic [LVL_W-1:0]  cmdTgt;

    assign cmdReadyO = !rstI && !faultI && (state == IDLE || state == RUN);
    assign accept    = cmdValidI && cmdReadyO;
    assign cmdTgt    = LVL_W'(clampLvl(32'(cmdLvlI), MAX_LVL));

    // One timer serves both the pulse pacing and the coast interval; they never overlap.
    motoro3_pace_timer #(
        .CNT_W (PACE_W)
    ) u_pace (
        .clkI     (clkI),
        .rstI     (rstI),
        .loadI    (timerLoad),
        .loadValI (timerVal),
        .tickO    (paceTick)
    );

`ifdef M3SCHED_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYC);

    logic [WDOG_W-1:0] wdogCnt;
    logic              wdogQ;

    assign wdogTrip = (state == RAMP || state == RUN) && !accept &&
                      (wdogCnt == WDOG_W'(WDOG_CYC - 1));

    // Watchdog: count cycles without a command while the motor is commanded to turn.
    always_ff @(posedge clkI) begin
        if (rstI) begin
            wdogCnt <= '0;
            wdogQ   <= 1'b0;
        end else begin
            if (accept || wdogTrip || state == IDLE || state == FAULT) begin
                wdogCnt <= '0;
            end else if (state == RAMP || state == RUN) begin
                wdogCnt <= wdogCnt + 1'b1;
            end
            if (accept) begin
                wdogQ <= 1'b0;
            end else if (wdogTrip && !faultI) begin
                wdogQ <= 1'b1;
            end
        end
    end

    assign wdogO = wdogQ;
`else
    assign wdogTrip = 1'b0;
`endif

    // State register.
    always_ff @(posedge clkI) begin
        if (rstI) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state, target/level bookkeeping and pulse decisions.
    always_comb begin
        // NOTE: every signal this block drives gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        stateNext     = state;
        tgtNext       = tgt;
        curNext       = cur;
        invNext       = invQ;
        incNext       = 1'b0;
        decNext       = 1'b0;
        pendValidNext = pendValid;
        pendDirNext   = pendDir;
        pendTgtNext   = pendTgt;
        timerLoad     = 1'b0;
        timerVal      = STEP_LOAD;

        unique case (state)
            IDLE: begin
                if (accept && cmdRunI) begin
                    tgtNext   = cmdTgt;
                    invNext   = cmdDirI;
                    stateNext = START;
                end
            end
            START: begin
                timerLoad = 1'b1;
                stateNext = RAMP;
            end
            RAMP, BRAKE: begin
                if (cur == tgt) begin
                    if (state == RAMP) begin
                        stateNext = RUN;
                    end else begin
                        stateNext = COAST;
                        timerLoad = 1'b1;
                        timerVal  = COAST_LOAD;
                    end
                end else if (paceTick) begin
                    timerLoad = 1'b1;
                    if (cur < tgt) begin
                        if (cur < LVL_MAX) begin
                            incNext = 1'b1;
                            curNext = cur + 1'b1;
                        end
                    end else if (cur != '0) begin
                        decNext = 1'b1;
                        curNext = cur - 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    timerLoad = 1'b1;
                    if (!cmdRunI) begin
                        tgtNext       = '0;
                        pendValidNext = 1'b0;
                        stateNext     = BRAKE;
                    end else if (cmdDirI != invQ) begin
                        pendValidNext = 1'b1;
                        pendDirNext   = cmdDirI;
                        pendTgtNext   = cmdTgt;
                        tgtNext       = '0;
                        stateNext     = BRAKE;
                    end else if (cmdTgt != tgt) begin
                        tgtNext   = cmdTgt;
                        stateNext = RAMP;
                    end else begin
                        timerLoad = 1'b0;
                    end
                end
            end
            COAST: begin
                if (paceTick) begin
                    if (pendValid) begin
                        invNext       = pendDir;
                        tgtNext       = pendTgt;
                        pendValidNext = 1'b0;
                        stateNext     = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            FAULT: begin
                curNext       = '0;
                pendValidNext = 1'b0;
                if (faultClrI && !faultI) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // A watchdog expiry behaves like an accepted stop command.
        if (wdogTrip) begin
            stateNext     = BRAKE;
            tgtNext       = '0;
            pendValidNext = 1'b0;
            curNext       = cur;
            incNext       = 1'b0;
            decNext       = 1'b0;
            timerLoad     = 1'b1;
            timerVal      = STEP_LOAD;
        end

        // A fault overrides any accept, tick or watchdog action in the same cycle.
        if (faultI) begin
            stateNext     = FAULT;
            tgtNext       = tgt;
            curNext       = '0;
            invNext       = invQ;
            incNext       = 1'b0;
            decNext       = 1'b0;
            pendValidNext = 1'b0;
            timerLoad     = 1'b0;
        end
    end

    // Datapath and driver-facing output registers; levels follow the next state.
    always_ff @(posedge clkI) begin
        if (rstI) begin
            tgt        <= '0;
            cur        <= '0;
            invQ       <= 1'b0;
            pendValid  <= 1'b0;
            pendDir    <= 1'b0;
            pendTgt    <= '0;
            startQ     <= 1'b0;
            forceStopQ <= 1'b0;
            incQ       <= 1'b0;
            decQ       <= 1'b0;
        end else begin
            tgt        <= tgtNext;
            cur        <= curNext;
            invQ       <= invNext;
            pendValid  <= pendValidNext;
            pendDir    <= pendDirNext;
            pendTgt    <= pendTgtNext;
            startQ     <= (stateNext inside {START, RAMP, RUN, BRAKE});
            forceStopQ <= (stateNext == FAULT);
            incQ       <= incNext;
            decQ       <= decNext;
        end
    end

    assign m3startO     = startQ;
    assign m3forceStopO = forceStopQ;
    assign m3invRotateO = invQ;
    assign m3freqINCo   = incQ;
    assign m3freqDECo   = decQ;
    assign curLvlO      = cur;
    assign busyO        = !(state == IDLE || state == RUN);

endmodule

// File: tb/tb_motoro3_ramp_sched.sv
// Self-checking bench for motoro3_ramp_sched (STEP_CYC=4, COAST_CYC=8).
// With M3SCHED_WDOG_EN defined it also exercises the command watchdog.
module tb_motoro3_ramp_sched;

    localparam int STEP  = 4;
    localparam int COAST = 8;
    localparam int WDOG  = 64;

    logic       clkI = 1'b0;
    logic       rstI;
    logic       cmdValidI, cmdReadyO, cmdRunI, cmdDirI;
    logic [3:0] cmdLvlI;
    logic       faultI, faultClrI;
    logic       m3startO, m3forceStopO, m3invRotateO, m3freqINCo, m3freqDECo;
    logic [3:0] curLvlO;
    logic       busyO;
`ifdef M3SCHED_WDOG_EN
    logic       wdogO;
`endif

    motoro3_ramp_sched #(
        .LVL_W     (4),
        .MAX_LVL   (12),
        .STEP_CYC  (STEP),
        .COAST_CYC (COAST)
`ifdef M3SCHED_WDOG_EN
        ,
        .WDOG_CYC  (WDOG)
`endif
    ) dut (
        .clkI         (clkI),
        .rstI         (rstI),
        .cmdValidI    (cmdValidI),
        .cmdReadyO    (cmdReadyO),
        .cmdRunI      (cmdRunI),
        .cmdDirI      (cmdDirI),
        .cmdLvlI      (cmdLvlI),
        .faultI       (faultI),
        .faultClrI    (faultClrI),
        .m3startO     (m3startO),
        .m3forceStopO (m3forceStopO),
        .m3invRotateO (m3invRotateO),
        .m3freqINCo   (m3freqINCo),
        .m3freqDECo   (m3freqDECo),
        .curLvlO      (curLvlO),
        .busyO        (busyO)
`ifdef M3SCHED_WDOG_EN
        ,
        .wdogO        (wdogO)
`endif
    );

    always #5 clkI = ~clkI;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    // Scoreboard of expected INC/DEC pulses, each with the level it must show.
    typedef struct {
        logic       isInc;
        logic [3:0] lvl;
    } pulse_t;
    pulse_t expQ[$];

    task automatic pushPulses(input int fromLvl, input int nDec, input int nInc);
        int l = fromLvl;
        for (int i = 0; i < nDec; i++) begin
            l--;
            expQ.push_back('{1'b0, 4'(l)});
        end
        for (int i = 0; i < nInc; i++) begin
            l++;
            expQ.push_back('{1'b1, 4'(l)});
        end
    endtask

    // Pulse monitor: pops the scoreboard, checks spacing, direction-change safety, coast length.
    int         cyc       = 0;
    int         lastPulse = -1000;
    int         lowCnt    = 0;
    int         lastLow   = 0;
    logic       prevInv   = 1'b0;
    logic       prevStart = 1'b0;
    logic [3:0] prevCur   = 4'd0;

    always @(posedge clkI) cyc <= cyc + 1;

    always @(negedge clkI) begin
        pulse_t p;
        if (rstI) begin
            lastPulse = -1000;
        end else begin
            if (m3freqINCo || m3freqDECo) begin
                check("inc_dec_exclusive", 32'(m3freqINCo & m3freqDECo), 0);
                if (expQ.size() == 0) begin
                    check("unexpected_pulse", 32'({m3freqINCo, m3freqDECo}), 0);
                end else begin
                    p = expQ.pop_front();
                    check("pulse_kind", 32'(m3freqINCo), 32'(p.isInc));
                    check("pulse_lvl", 32'(curLvlO), 32'(p.lvl));
                end
                check("pulse_spacing_ok", 32'(cyc - lastPulse >= STEP), 1);
                lastPulse = cyc;
            end
            if (m3invRotateO !== prevInv) begin
                check("inv_change_start_cur", 32'({prevStart, prevCur != 4'd0}), 0);
            end
        end
        if (!m3startO) begin
            lowCnt++;
        end else begin
            if (lowCnt > 0) lastLow = lowCnt;
            lowCnt = 0;
        end
        prevInv   = m3invRotateO;
        prevStart = m3startO;
        prevCur   = curLvlO;
    end

    task automatic sendCmd(input logic run, input logic dir, input logic [3:0] lvl);
        @(negedge clkI);
        cmdValidI = 1'b1;
        cmdRunI   = run;
        cmdDirI   = dir;
        cmdLvlI   = lvl;
        for (int i = 0; i < 50 && !cmdReadyO; i++) @(negedge clkI);
        check("cmd_ready", 32'(cmdReadyO), 1);
        @(posedge clkI);
        #1 cmdValidI = 1'b0;
    endtask

    task automatic waitSettle(input int budget);
        int n = 0;
        do begin
            @(negedge clkI);
            n++;
        end while (busyO && n < budget);
        check("settled_busy", 32'(busyO), 0);
    endtask

    task automatic waitLvl(input logic [3:0] lvl, input int budget);
        int n = 0;
        while (curLvlO !== lvl && n < budget) begin
            @(negedge clkI);
            n++;
        end
        check("reach_lvl", 32'(curLvlO), 32'(lvl));
    endtask

    typedef struct {
        logic       run;
        logic       dir;
        logic [3:0] lvl;
        int         nDec;
        int         nInc;
        int         expLvl;
        logic       expInv;
        logic       expStart;
        int         expCoast;
    } vec_t;
    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int curExp;

        //           run   dir   lvl  dec inc lvl inv  start coast
        vecs[0]  = '{1'b1, 1'b0, 4'd3,  0,  3,  3, 1'b0, 1'b1, 0};
        vecs[1]  = '{1'b1, 1'b0, 4'd1,  2,  0,  1, 1'b0, 1'b1, 0};
        vecs[2]  = '{1'b1, 1'b0, 4'd15, 0, 11, 12, 1'b0, 1'b1, 0};
        vecs[3]  = '{1'b1, 1'b0, 4'd3,  9,  0,  3, 1'b0, 1'b1, 0};
        vecs[4]  = '{1'b1, 1'b1, 4'd2,  3,  2,  2, 1'b1, 1'b1, 8};
        vecs[5]  = '{1'b1, 1'b1, 4'd2,  0,  0,  2, 1'b1, 1'b1, 0};
        vecs[6]  = '{1'b0, 1'b0, 4'd0,  2,  0,  0, 1'b1, 1'b0, 0};
        vecs[7]  = '{1'b1, 1'b0, 4'd5,  0,  5,  5, 1'b0, 1'b1, 0};
        vecs[8]  = '{1'b0, 1'b1, 4'd9,  5,  0,  0, 1'b0, 1'b0, 0};
        vecs[9]  = '{1'b1, 1'b0, 4'd0,  0,  0,  0, 1'b0, 1'b1, 0};
        vecs[10] = '{1'b0, 1'b0, 4'd0,  0,  0,  0, 1'b0, 1'b0, 0};

        rstI      = 1'b1;
        cmdValidI = 1'b0;
        cmdRunI   = 1'b0;
        cmdDirI   = 1'b0;
        cmdLvlI   = 4'd0;
        faultI    = 1'b0;
        faultClrI = 1'b0;

        // Reset state.
        repeat (3) @(negedge clkI);
        check("rst_ready_low", 32'(cmdReadyO), 0);
        check("rst_start", 32'(m3startO), 0);
        check("rst_force", 32'(m3forceStopO), 0);
        check("rst_lvl", 32'(curLvlO), 0);
        check("rst_busy", 32'(busyO), 0);
        rstI = 1'b0;
        #1 check("post_rst_ready", 32'(cmdReadyO), 1);

        // Command table.
        curExp = 0;
        foreach (vecs[i]) begin
            pushPulses(curExp, vecs[i].nDec, vecs[i].nInc);
            lastLow = 0;
            sendCmd(vecs[i].run, vecs[i].dir, vecs[i].lvl);
            waitSettle(400);
            check($sformatf("v%0d_lvl", i), 32'(curLvlO), 32'(vecs[i].expLvl));
            check($sformatf("v%0d_inv", i), 32'(m3invRotateO), 32'(vecs[i].expInv));
            check($sformatf("v%0d_start", i), 32'(m3startO), 32'(vecs[i].expStart));
            check($sformatf("v%0d_force", i), 32'(m3forceStopO), 0);
            check($sformatf("v%0d_queue", i), 32'(expQ.size()), 0);
            if (vecs[i].expCoast != 0) begin
                check($sformatf("v%0d_coast", i), 32'(lastLow), 32'(vecs[i].expCoast));
            end
            curExp = vecs[i].expLvl;
        end

        // Fault during a ramp at level 2.
        pushPulses(0, 0, 2);
        sendCmd(1'b1, 1'b0, 4'd5);
        waitLvl(4'd2, 100);
        faultI = 1'b1;
        @(negedge clkI);
        check("f_force", 32'(m3forceStopO), 1);
        check("f_start", 32'(m3startO), 0);
        check("f_lvl", 32'(curLvlO), 0);
        check("f_busy", 32'(busyO), 1);
        check("f_ready", 32'(cmdReadyO), 0);
        repeat (6) @(negedge clkI);
        faultClrI = 1'b1;
        @(negedge clkI);
        faultClrI = 1'b0;
        check("f_clr_while_fault", 32'(m3forceStopO), 1);
        faultI = 1'b0;
        @(negedge clkI);
        check("f_no_clr", 32'(m3forceStopO), 1);
        faultClrI = 1'b1;
        @(negedge clkI);
        faultClrI = 1'b0;
        check("f_exit_force", 32'(m3forceStopO), 0);
        check("f_exit_busy", 32'(busyO), 0);
        check("f_exit_ready", 32'(cmdReadyO), 1);
        check("f_queue", 32'(expQ.size()), 0);

        // Fault and a command in the same cycle: fault wins.
        @(negedge clkI);
        cmdValidI = 1'b1;
        cmdRunI   = 1'b1;
        cmdDirI   = 1'b1;
        cmdLvlI   = 4'd4;
        faultI    = 1'b1;
        #1 check("fa_ready", 32'(cmdReadyO), 0);
        @(negedge clkI);
        cmdValidI = 1'b0;
        check("fa_force", 32'(m3forceStopO), 1);
        check("fa_start", 32'(m3startO), 0);
        check("fa_inv", 32'(m3invRotateO), 0);
        faultI    = 1'b0;
        faultClrI = 1'b1;
        @(negedge clkI);
        faultClrI = 1'b0;
        check("fa_exit", 32'(m3forceStopO), 0);

        // Reset asserted on the cycle a pulse would otherwise fire.
        pushPulses(0, 0, 2);
        sendCmd(1'b1, 1'b0, 4'd6);
        waitLvl(4'd2, 100);
        repeat (3) @(negedge clkI);
        rstI = 1'b1;
        #1 check("r_ready", 32'(cmdReadyO), 0);
        @(negedge clkI);
        check("r_start", 32'(m3startO), 0);
        check("r_inc", 32'(m3freqINCo), 0);
        check("r_dec", 32'(m3freqDECo), 0);
        check("r_lvl", 32'(curLvlO), 0);
        check("r_busy", 32'(busyO), 0);
        check("r_force", 32'(m3forceStopO), 0);
        check("r_queue", 32'(expQ.size()), 0);
        rstI = 1'b0;
        @(negedge clkI);
        check("r_release_ready", 32'(cmdReadyO), 1);
        check("r_release_start", 32'(m3startO), 0);

`ifdef M3SCHED_WDOG_EN
        // No command for WDOG cycles in RUN: brake to zero, coast, idle, sticky flag.
        pushPulses(0, 0, 1);
        pushPulses(1, 1, 0);
        sendCmd(1'b1, 1'b0, 4'd1);
        waitSettle(100);
        check("w_run_lvl", 32'(curLvlO), 1);
        check("w_flag_early", 32'(wdogO), 0);
        begin
            int n = 0;
            while (!busyO && n < 200) begin
                @(negedge clkI);
                n++;
            end
        end
        check("w_fired", 32'(busyO), 1);
        waitSettle(300);
        check("w_flag", 32'(wdogO), 1);
        check("w_lvl", 32'(curLvlO), 0);
        check("w_start", 32'(m3startO), 0);
        check("w_queue", 32'(expQ.size()), 0);
        sendCmd(1'b1, 1'b0, 4'd0);
        check("w_flag_clr", 32'(wdogO), 0);
        waitSettle(50);
        sendCmd(1'b0, 1'b0, 4'd0);
        waitSettle(100);
`endif

        repeat (2) @(negedge clkI);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
